// File: rtl/regfile_writeback_arbiter.sv
// Purpose: merges ALU and load results into the single register-file write port (x0 writes dropped).
// Latency: entry accepted at edge t is popped at edge t+1 at the earliest and shows on write_reg for one cycle.
// Backpressure: per-source ready = registered FIFO count below depth; a full FIFO never passes through.

module rwa_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_head_dat,
  output logic         o_empty,
  output logic         o_full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Storage is not reset: slots are only meaningful while r_count covers them.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  // Wrapping pointers and occupancy; push and pop together leave the count alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CNT_W'(DEPTH));
endmodule

module regfile_writeback_arbiter #(
  parameter int DATA_WIDTH   = 64,
  parameter int NUM_REGS     = 32,
  parameter int NUM_REGS_LOG = $clog2(NUM_REGS),
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [NUM_REGS_LOG-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]   alu_data,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [NUM_REGS_LOG-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0]   mem_data,
  output logic [NUM_REGS_LOG-1:0] write_reg,
  output logic [DATA_WIDTH-1:0]   write_data,
  output logic                    busy
);
  typedef struct packed {
    logic [NUM_REGS_LOG-1:0] rd;
    logic [DATA_WIDTH-1:0]   dat;
  } wb_ent_t;

  localparam int ENT_W = $bits(wb_ent_t);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  wb_ent_t          w_alu_in;
  wb_ent_t          w_mem_in;
  wb_ent_t          w_alu_head;
  wb_ent_t          w_mem_head;
  logic             w_alu_empty;
  logic             w_mem_empty;
  logic             w_alu_full;
  logic             w_mem_full;
  logic             w_alu_push;
  logic             w_mem_push;
  logic             w_pop_alu;
  logic             w_pop_mem;
  logic             w_starved;
  logic [STV_W-1:0] r_starve;

  assign w_alu_in  = '{rd: alu_rd, dat: alu_data};
  assign w_mem_in  = '{rd: mem_rd, dat: mem_data};
  assign alu_ready = !w_alu_full;
  assign mem_ready = !w_mem_full;

  // A handshake to x0 completes but is never queued: x0 is hardwired in the register file.
  assign w_alu_push = alu_valid && alu_ready && (alu_rd != '0);
  assign w_mem_push = mem_valid && mem_ready && (mem_rd != '0);

  rwa_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_alu_push),
    .i_push_dat (w_alu_in),
    .i_pop      (w_pop_alu),
    .o_head_dat (w_alu_head),
    .o_empty    (w_alu_empty),
    .o_full     (w_alu_full)
  );

  rwa_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH)) u_mem_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_mem_push),
    .i_push_dat (w_mem_in),
    .i_pop      (w_pop_mem),
    .o_head_dat (w_mem_head),
    .o_empty    (w_mem_empty),
    .o_full     (w_mem_full)
  );

  assign w_starved = (r_starve == STV_W'(STARVE_LIMIT));

  // Fixed priority to loads, except a starved ALU head is forced through.
  always_comb begin
    w_pop_alu = 1'b0;
    w_pop_mem = 1'b0;
    if (w_starved && !w_alu_empty) begin
      w_pop_alu = 1'b1;
    end else if (!w_mem_empty) begin
      w_pop_mem = 1'b1;
    end else if (!w_alu_empty) begin
      w_pop_alu = 1'b1;
    end
  end

  // Count consecutive ALU losses; any ALU win or an empty ALU FIFO clears the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve <= '0;
    end else if (w_pop_alu || w_alu_empty) begin
      r_starve <= '0;
    end else if (w_pop_mem && !w_starved) begin
      r_starve <= r_starve + STV_W'(1);
    end
  end

  // Registered write port: one cycle per popped entry, 0/0 otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_reg  <= '0;
      write_data <= '0;
    end else if (w_pop_alu) begin
      write_reg  <= w_alu_head.rd;
      write_data <= w_alu_head.dat;
    end else if (w_pop_mem) begin
      write_reg  <= w_mem_head.rd;
      write_data <= w_mem_head.dat;
    end else begin
      write_reg  <= '0;
      write_data <= '0;
    end
  end

  assign busy = !w_alu_empty || !w_mem_empty || (write_reg != '0);
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Bench for regfile_writeback_arbiter: directed scenarios plus random traffic against a queue model.
// Inputs change just after the falling edge; outputs are sampled on the falling edge.
// Upstream holds rd/data while valid is stalled, as the handshake requires.

module tb_regfile_writeback_arbiter;
  localparam int DW    = 64;
  localparam int NR    = 32;
  localparam int RL    = 5;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_valid, alu_ready, mem_valid, mem_ready, busy;
  logic [RL-1:0] alu_rd, mem_rd, write_reg;
  logic [DW-1:0] alu_data, mem_data, write_data;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_writeback_arbiter #(
    .DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_REGS_LOG(RL), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .write_reg(write_reg), .write_data(write_data), .busy(busy)
  );

  // Reference model: two queues, a loss counter and the last write, advanced once per rising edge.
  typedef struct packed {
    logic [RL-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          m_alu_q[$];
  ent_t          m_mem_q[$];
  int            m_losses;
  int            m_winner;
  bit            m_alu_acc, m_mem_acc;
  ent_t          m_ent;
  logic [RL-1:0] m_wreg;
  logic [DW-1:0] m_wdata;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_alu_q.delete();
      m_mem_q.delete();
      m_losses = 0;
      m_wreg   = '0;
      m_wdata  = '0;
    end else begin
      m_alu_acc = alu_valid && (m_alu_q.size() < DEPTH);
      m_mem_acc = mem_valid && (m_mem_q.size() < DEPTH);
      if (m_alu_q.size() > 0 && m_losses >= LIMIT) m_winner = 2;
      else if (m_mem_q.size() > 0)                 m_winner = 1;
      else if (m_alu_q.size() > 0)                 m_winner = 2;
      else                                         m_winner = 0;
      if (m_winner == 1 && m_alu_q.size() > 0) m_losses = (m_losses < LIMIT) ? m_losses + 1 : LIMIT;
      else                                     m_losses = 0;
      if (m_winner == 1)      m_ent = m_mem_q.pop_front();
      else if (m_winner == 2) m_ent = m_alu_q.pop_front();
      else                    m_ent = '0;
      m_wreg  = m_ent.rd;
      m_wdata = m_ent.data;
      if (m_alu_acc && alu_rd != 0) m_alu_q.push_back('{rd: alu_rd, data: alu_data});
      if (m_mem_acc && mem_rd != 0) m_mem_q.push_back('{rd: mem_rd, data: mem_data});
    end
  end

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (write_reg !== 5'd0) begin n_fail++; $display("FAIL reset_wreg: got %0d want 0", write_reg); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got alu=%b mem=%b want 1/1", alu_ready, mem_ready); end
    n_cmp++; if (write_data !== 64'd0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", write_data); end
  endtask

  task automatic test_single_alu();
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hDEAD_BEEF;
    @(negedge clk);
    alu_valid = 1'b0;
    n_cmp++; if (write_reg !== 5'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_t0: got wreg=%0d busy=%b want 0/1", write_reg, busy); end
    @(negedge clk);
    n_cmp++; if (write_reg !== 5'd5 || write_data !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL single_write: got %0d/%h want 5/deadbeef", write_reg, write_data); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_hi: got %b want 1", busy); end
    @(negedge clk);
    n_cmp++; if (write_reg !== 5'd0 || write_data !== 64'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_after: got %0d/%h busy=%b want 0/0/0", write_reg, write_data, busy); end
  endtask

  task automatic test_priority();
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h3333;
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 64'h7777;
    @(negedge clk);
    idle_inputs();
    n_cmp++; if (write_reg !== 5'd0) begin n_fail++; $display("FAIL prio_t0: got %0d want 0", write_reg); end
    @(negedge clk);
    n_cmp++; if (write_reg !== 5'd7 || write_data !== 64'h7777) begin n_fail++; $display("FAIL prio_first: got %0d/%h want 7/7777", write_reg, write_data); end
    @(negedge clk);
    n_cmp++; if (write_reg !== 5'd3 || write_data !== 64'h3333) begin n_fail++; $display("FAIL prio_second: got %0d/%h want 3/3333", write_reg, write_data); end
    @(negedge clk);
    n_cmp++; if (write_reg !== 5'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL prio_idle: got %0d busy=%b want 0/0", write_reg, busy); end
  endtask

  task automatic test_x0_discard();
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hFFFF;
    n_cmp++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready_pre: got %b want 1", alu_ready); end
    @(negedge clk);
    idle_inputs();
    n_cmp++; if (write_reg !== 5'd0 || busy !== 1'b0 || alu_ready !== 1'b1) begin n_fail++; $display("FAIL x0_after_accept: got wreg=%0d busy=%b rdy=%b want 0/0/1", write_reg, busy, alu_ready); end
    @(negedge clk);
    n_cmp++; if (write_reg !== 5'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL x0_next: got wreg=%0d busy=%b want 0/0", write_reg, busy); end
  endtask

  task automatic test_starvation();
    logic [RL-1:0] got_rd[$];
    logic [DW-1:0] got_dat[$];
    int            exp_rd[9];
    int            k;
    bit            af, mf;
    exp_rd = '{1, 2, 3, 4, 9, 5, 6, 7, 8};
    @(negedge clk);
    k = 1;
    mem_valid = 1'b1; mem_rd = 5'd1; mem_data = 64'h1001;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h9999;
    for (int c = 0; c < 40; c++) begin
      af = alu_valid && alu_ready;
      mf = mem_valid && mem_ready;
      @(negedge clk);
      if (write_reg != 0) begin got_rd.push_back(write_reg); got_dat.push_back(write_data); end
      if (af) alu_valid = 1'b0;
      if (mf) begin
        if (k < 8) begin k++; mem_rd = RL'(k); mem_data = 64'h1000 + DW'(k); end
        else mem_valid = 1'b0;
      end
      if (!busy && !mem_valid && !alu_valid) break;
    end
    idle_inputs();
    n_cmp++; if (got_rd.size() != 9) begin n_fail++; $display("FAIL starve_count: got %0d writes want 9", got_rd.size()); end
    for (int i = 0; i < 9 && i < got_rd.size(); i++) begin
      n_cmp++;
      if (got_rd[i] !== RL'(exp_rd[i]) || got_dat[i] !== ((exp_rd[i] == 9) ? 64'h9999 : 64'h1000 + DW'(exp_rd[i])))
        begin n_fail++; $display("FAIL starve_seq[%0d]: got %0d/%h want rd %0d", i, got_rd[i], got_dat[i], exp_rd[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [RL-1:0] alu_got[$];
    logic [DW-1:0] alu_dat[$];
    logic [DW-1:0] mem_got[$];
    int            ai, mk, acc_at_stall, rise_cyc, w20_cyc;
    bit            af, mf, stall_seen;
    ai = 0; mk = 0; acc_at_stall = -1; rise_cyc = -1; w20_cyc = -2; stall_seen = 1'b0;
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 64'hA000;
    mem_valid = 1'b1; mem_rd = 5'd23; mem_data = 64'hB000;
    for (int c = 1; c <= 80; c++) begin
      af = alu_valid && alu_ready;
      mf = mem_valid && mem_ready;
      @(negedge clk);
      if (write_reg >= 20 && write_reg <= 22) begin
        alu_got.push_back(write_reg); alu_dat.push_back(write_data);
        if (write_reg == 20) w20_cyc = c;
      end else if (write_reg != 0) mem_got.push_back(write_data);
      if (af) begin
        ai++;
        if (ai < 3) begin alu_rd = RL'(20 + ai); alu_data = 64'hA000 + DW'(ai); end
        else alu_valid = 1'b0;
      end
      if (mf) begin
        mk++;
        if (mk < 16) begin mem_rd = RL'(23 + mk % 9); mem_data = 64'hB000 + DW'(mk); end
        else mem_valid = 1'b0;
      end
      if (alu_valid && !alu_ready && !stall_seen) begin stall_seen = 1'b1; acc_at_stall = ai; end
      if (stall_seen && alu_ready && rise_cyc < 0) rise_cyc = c;
      if (!busy && !alu_valid && !mem_valid) break;
    end
    idle_inputs();
    n_cmp++; if (acc_at_stall != 2) begin n_fail++; $display("FAIL bp_stall_after: got %0d accepts want 2", acc_at_stall); end
    n_cmp++; if (rise_cyc != w20_cyc) begin n_fail++; $display("FAIL bp_ready_return: got cycle %0d want %0d (first ALU pop)", rise_cyc, w20_cyc); end
    n_cmp++; if (alu_got.size() != 3) begin n_fail++; $display("FAIL bp_alu_count: got %0d want 3", alu_got.size()); end
    for (int i = 0; i < 3 && i < alu_got.size(); i++) begin
      n_cmp++;
      if (alu_got[i] !== RL'(20 + i) || alu_dat[i] !== 64'hA000 + DW'(i))
        begin n_fail++; $display("FAIL bp_alu_order[%0d]: got %0d/%h want %0d", i, alu_got[i], alu_dat[i], 20 + i); end
    end
    n_cmp++; if (mem_got.size() != 16) begin n_fail++; $display("FAIL bp_mem_count: got %0d want 16", mem_got.size()); end
    for (int i = 0; i < mem_got.size(); i++) begin
      n_cmp++;
      if (mem_got[i] !== 64'hB000 + DW'(i)) begin n_fail++; $display("FAIL bp_mem_order[%0d]: got %h want %h", i, mem_got[i], 64'hB000 + DW'(i)); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 64'hD13;
    mem_valid = 1'b1; mem_rd = 5'd14; mem_data = 64'hD14;
    repeat (3) @(negedge clk);
    idle_inputs();
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (write_reg !== 5'd0 || write_data !== 64'd0) begin n_fail++; $display("FAIL rstmid_out: got %0d/%h want 0/0", write_reg, write_data); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_post: got alu=%b mem=%b busy=%b want 1/1/0", alu_ready, mem_ready, busy); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (write_reg !== 5'd0) begin n_fail++; $display("FAIL rstmid_stale[%0d]: got %0d want 0", i, write_reg); end
    end
  endtask

  task automatic test_random();
    bit af, mf;
    af = 1'b0; mf = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      n_cmp++; if (write_reg !== m_wreg || write_data !== m_wdata) begin n_fail++; $display("FAIL rand_write cyc %0d: got %0d/%h want %0d/%h", c, write_reg, write_data, m_wreg, m_wdata); end
      n_cmp++; if (alu_ready !== (m_alu_q.size() < DEPTH) || mem_ready !== (m_mem_q.size() < DEPTH)) begin n_fail++; $display("FAIL rand_ready cyc %0d: got alu=%b mem=%b want alu=%b mem=%b", c, alu_ready, mem_ready, m_alu_q.size() < DEPTH, m_mem_q.size() < DEPTH); end
      n_cmp++; if (busy !== (m_alu_q.size() != 0 || m_mem_q.size() != 0 || m_wreg != 0)) begin n_fail++; $display("FAIL rand_busy cyc %0d: got %b", c, busy); end
      if (!(alu_valid && !af)) begin
        alu_valid = ($urandom_range(0, 3) != 0) && (c < 580);
        alu_rd    = ($urandom_range(0, 7) == 0) ? RL'(0) : RL'($urandom_range(1, 31));
        alu_data  = {$urandom, $urandom};
      end
      if (!(mem_valid && !mf)) begin
        mem_valid = ($urandom_range(0, 1) != 0) && (c < 580);
        mem_rd    = ($urandom_range(0, 7) == 0) ? RL'(0) : RL'($urandom_range(1, 31));
        mem_data  = {$urandom, $urandom};
      end
      af = alu_valid && alu_ready;
      mf = mem_valid && mem_ready;
    end
    idle_inputs();
    for (int c = 0; c < 20 && busy; c++) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rand_drain: busy=%b after drain budget want 0", busy); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_alu();
    test_priority();
    test_x0_discard();
    test_starvation();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_writeback_arbiter.md
Name: regfile_writeback_arbiter

Overview:
- Producer side of the register file write port: owns write_reg/write_data and drives them into register_file.
- Merges results from the single-cycle ALU and the variable-latency memory/load unit.
- Each source has a valid/ready handshake and its own small FIFO. Arbitration is fixed-priority (MEM first) with an ALU anti-starvation override.
- Write intent is signalled only by write_reg != 0; write_reg = 0 means no write, because x0 is hardwired to zero in the register file.

Parameters:
DATA_WIDTH, 64, result/register width
NUM_REGS, 32, architectural register count
NUM_REGS_LOG, $clog2(NUM_REGS), register index width
FIFO_DEPTH, 2, entries per source FIFO (power of two, >= 2)
STARVE_LIMIT, 4, consecutive ALU losses before ALU is forced to win

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
alu_valid  input  1  ALU result offered
alu_ready  output  1  ALU FIFO can accept
alu_rd  input  NUM_REGS_LOG  ALU destination register
alu_data  input  DATA_WIDTH  ALU result
mem_valid  input  1  load result offered
mem_ready  output  1  MEM FIFO can accept
mem_rd  input  NUM_REGS_LOG  load destination register
mem_data  input  DATA_WIDTH  load result
write_reg  output  NUM_REGS_LOG  to register_file write_reg; 0 = no write
write_data  output  DATA_WIDTH  to register_file write_data
busy  output  1  any FIFO non-empty or write_reg != 0

Behaviour:
- Reset (async, active-high): both FIFOs empty, pointers/counts 0, starve counter 0, write_reg = 0, write_data = 0, busy = 0, alu_ready = mem_ready = 1 once reset deasserts. In-flight entries are discarded.
- Handshake: a transfer occurs on a rising edge with valid && ready. x_ready = (count_x < FIFO_DEPTH), taken from the registered count. No same-cycle pass-through when full, even if a pop occurs that edge. Upstream holds rd/data stable while valid && !ready.
- x0 filter: a transfer with rd == 0 completes the handshake but is not enqueued.
- FIFO: per-source circular buffer with wrapping pointers and order preserved within a source. Push and pop on the same edge leave the count unchanged.
- Arbitration is evaluated each cycle on the FIFO heads:
  - starve == STARVE_LIMIT and ALU non-empty -> pop ALU.
  - else MEM non-empty -> pop MEM.
  - else ALU non-empty -> pop ALU.
  - else no pop.
- Starve counter:
  - increments (saturating at STARVE_LIMIT) when MEM is popped while ALU is non-empty;
  - clears to 0 when ALU is popped or ALU is empty.
- Output register: on each edge, write_reg/write_data <= the popped entry's rd/data, or 0/0 when nothing is popped. write_reg is never held across cycles, so each entry produces exactly one write cycle.
- Latency: entry accepted at edge t -> earliest appearance on write_reg during cycle t+1..t+2 -> the register file commits it at edge t+2. Sustained throughput is one write per cycle.
- Cross-source ordering is not guaranteed. The issue logic must not have writes to the same rd pending in both sources at once. Violations are a checker error, not handled here.
- busy is combinational from registered state.

Test Plan:
- Reset mid-stream: fill both FIFOs, assert reset between edges -> write_reg = 0, write_data = 0, busy = 0 immediately (no edge needed). Both readies = 1 after deassert, and the old entries never appear.
- Single ALU write: alu rd=5, data=0xDEAD_BEEF accepted at edge t -> write_reg = 5, write_data = 0xDEADBEEF during cycle t+1 only, then 0/0; busy falls after that cycle.
- Priority: ALU rd=3 and MEM rd=7 accepted on the same edge -> write sequence 7 then 3 on consecutive cycles.
- Starvation (STARVE_LIMIT=4): MEM valid every cycle with rd=1..N, one ALU entry rd=9 queued -> exactly 4 MEM writes, then rd=9, then MEM resumes; starve counter returns to 0.
- x0 discard: alu rd=0 data=0xFFFF accepted -> handshake completes, write_reg stays 0, busy stays 0, FIFO count unchanged.
- Backpressure/wrap (FIFO_DEPTH=2): MEM streams continuously while 3 ALU results are offered -> alu_ready = 0 after 2 accepts. The third is held until the first ALU pop, and all 3 ALU writes appear in order after pointer wrap.
